// File: rtl/roce_arb_pkg.sv
// Shared definitions for the RoCE TX metadata arbiter:
// opcodes, requester index type and the payload classifier.
package roce_arb_pkg;

    localparam logic [2:0] RC_RDMA_READ  = 3'd0;
    localparam logic [2:0] RC_RDMA_WRITE = 3'd1;
    localparam logic [2:0] RC_SEND       = 3'd2;

    // Index type covers the largest supported requester count.
    localparam int N_REQ_MAX = 8;

    typedef logic [$clog2(N_REQ_MAX)-1:0] req_idx_t;

    function automatic logic is_data_op(input logic [2:0] opcode);
        return opcode != RC_RDMA_READ;
    endfunction

endpackage

// File: rtl/roce_grant_fifo.sv
// In-order FIFO of granted requester indices for payload steering.
// Push and pop may coincide in any occupancy; a pop frees a full slot.
module roce_grant_fifo
    import roce_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  req_idx_t din,
    input  logic     pop,
    output req_idx_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    req_idx_t      mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          full_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = cnt_q == '0;
    assign full    = full_q;
    assign head    = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full_q | do_pop);

    always_comb begin
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q  <= cnt_d;
            full_q <= cnt_d == (AW+1)'(DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/roce_tx_meta_arbiter.sv
// Round-robin arbiter sharing the RoCE TX meta/data path between requesters;
// payloads follow the meta grant order through an in-order grant FIFO.
module roce_tx_meta_arbiter
    import roce_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int META_WIDTH  = 160,
    parameter int DATA_WIDTH  = 512,
    parameter int GFIFO_DEPTH = 8
) (
    input  logic                          net_clk,
    input  logic                          net_aresetn,
    input  logic [N_REQ-1:0]              s_meta_valid,
    output logic [N_REQ-1:0]              s_meta_ready,
    input  logic [N_REQ*META_WIDTH-1:0]   s_meta_data,
    input  logic [N_REQ-1:0]              s_data_valid,
    output logic [N_REQ-1:0]              s_data_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0]   s_data_data,
    input  logic [N_REQ*DATA_WIDTH/8-1:0] s_data_keep,
    input  logic [N_REQ-1:0]              s_data_last,
    output logic                          m_meta_valid,
    input  logic                          m_meta_ready,
    output logic [META_WIDTH-1:0]         m_meta_data,
    output logic                          m_data_valid,
    input  logic                          m_data_ready,
    output logic [DATA_WIDTH-1:0]         m_data_data,
    output logic [DATA_WIDTH/8-1:0]       m_data_keep,
    output logic                          m_data_last,
    output logic                          grant_fifo_full
);

    localparam int IW = $clog2(N_REQ);
    localparam int KW = DATA_WIDTH / 8;

    logic                  arb_en_q;
    logic [IW-1:0]         rr_q;
    logic [IW-1:0]         rr_d;
    logic                  meta_vld_q;
    logic [META_WIDTH-1:0] meta_q;

    logic                  found;
    logic [IW-1:0]         win;
    logic [IW:0]           sum;
    logic [META_WIDTH-1:0] win_meta;
    logic                  can_arb;
    logic                  grant;
    logic                  push;
    logic                  pop;

    req_idx_t              gf_head;
    logic                  gf_full;
    logic                  gf_empty;

    // First valid requester starting at rr_q, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
            if (!found && s_meta_valid[sum[IW-1:0]]) begin
                found = 1'b1;
                win   = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        win_meta = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IW'(i) == win) win_meta = s_meta_data[i*META_WIDTH +: META_WIDTH];
        end
    end

    // A full grant FIFO stalls every grant unless this cycle's pop frees a slot.
    assign can_arb = arb_en_q & (~meta_vld_q | m_meta_ready);
    assign grant   = can_arb & found & (~gf_full | pop);
    assign push    = grant & is_data_op(win_meta[2:0]);

    always_comb begin
        s_meta_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            s_meta_ready[i] = grant && (win == IW'(i));
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant) rr_d = (win == IW'(N_REQ-1)) ? '0 : win + IW'(1);
    end

    // arb_en_q keeps every ready low until the first edge after reset release.
    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            arb_en_q   <= 1'b0;
            rr_q       <= '0;
            meta_vld_q <= 1'b0;
            meta_q     <= '0;
        end else begin
            arb_en_q <= 1'b1;
            rr_q     <= rr_d;
            if (grant) begin
                meta_vld_q <= 1'b1;
                meta_q     <= win_meta;
            end else if (m_meta_ready) begin
                meta_vld_q <= 1'b0;
            end
        end
    end

    assign m_meta_valid = meta_vld_q;
    assign m_meta_data  = meta_q;

    always_comb begin
        m_data_valid = 1'b0;
        m_data_data  = '0;
        m_data_keep  = '0;
        m_data_last  = 1'b0;
        s_data_ready = '0;
        if (!gf_empty) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_idx_t'(i) == gf_head) begin
                    m_data_valid    = s_data_valid[i];
                    m_data_data     = s_data_data[i*DATA_WIDTH +: DATA_WIDTH];
                    m_data_keep     = s_data_keep[i*KW +: KW];
                    m_data_last     = s_data_last[i];
                    s_data_ready[i] = m_data_ready;
                end
            end
        end
    end

    assign pop = m_data_valid & m_data_ready & m_data_last;

    roce_grant_fifo #(
        .DEPTH (GFIFO_DEPTH)
    ) u_gfifo (
        .clk   (net_clk),
        .rst_n (net_aresetn),
        .push  (push),
        .din   (req_idx_t'(win)),
        .pop   (pop),
        .head  (gf_head),
        .full  (gf_full),
        .empty (gf_empty)
    );

    assign grant_fifo_full = gf_full;

endmodule

// File: tb/tb_roce_tx_meta_arbiter.sv
// Scoreboard bench for roce_tx_meta_arbiter: per-requester stimulus queues,
// expected meta/data queues checked as the stack-side handshakes occur.
module tb_roce_tx_meta_arbiter;
    import roce_arb_pkg::*;

    localparam int N  = 4;
    localparam int MW = 160;
    localparam int DW = 512;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic              net_clk;
    logic              net_aresetn;
    logic [N-1:0]      s_meta_valid;
    logic [N-1:0]      s_meta_ready;
    logic [N*MW-1:0]   s_meta_data;
    logic [N-1:0]      s_data_valid;
    logic [N-1:0]      s_data_ready;
    logic [N*DW-1:0]   s_data_data;
    logic [N*KW-1:0]   s_data_keep;
    logic [N-1:0]      s_data_last;
    logic              m_meta_valid;
    logic              m_meta_ready;
    logic [MW-1:0]     m_meta_data;
    logic              m_data_valid;
    logic              m_data_ready;
    logic [DW-1:0]     m_data_data;
    logic [KW-1:0]     m_data_keep;
    logic              m_data_last;
    logic              grant_fifo_full;

    int tests = 0;
    int fails = 0;

    logic [MW-1:0] mq [N][$];
    beat_t         dq [N][$];
    beat_t         hold [N][$];
    logic [MW-1:0] em [$];
    beat_t         ed [$];
    beat_t         pk [$];

    roce_tx_meta_arbiter #(
        .N_REQ(N), .META_WIDTH(MW), .DATA_WIDTH(DW), .GFIFO_DEPTH(8)
    ) dut (
        .net_clk(net_clk), .net_aresetn(net_aresetn),
        .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready),
        .s_meta_data(s_meta_data),
        .s_data_valid(s_data_valid), .s_data_ready(s_data_ready),
        .s_data_data(s_data_data), .s_data_keep(s_data_keep),
        .s_data_last(s_data_last),
        .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready),
        .m_meta_data(m_meta_data),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
        .m_data_data(m_data_data), .m_data_keep(m_data_keep),
        .m_data_last(m_data_last),
        .grant_fifo_full(grant_fifo_full)
    );

    initial net_clk = 1'b0;
    always #5 net_clk = ~net_clk;

    function automatic logic [MW-1:0] mk_meta(int id, int seq, logic [2:0] op);
        logic [MW-1:0] m;
        m = '0;
        m[2:0]     = op;
        m[15:8]    = 8'(seq);
        m[23:16]   = 8'(id);
        m[159:128] = $urandom;
        return m;
    endfunction

    task automatic mk_pkt(input int id, input int n);
        beat_t b;
        pk.delete();
        for (int j = 0; j < n; j++) begin
            for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom;
            b.d[7:0] = 8'(id);
            b.k = {$urandom, $urandom};
            b.l = (j == n - 1);
            pk.push_back(b);
        end
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            dq[i].delete();
            hold[i].delete();
        end
        em.delete();
        ed.delete();
    endtask

    function automatic bit all_empty();
        bit e;
        e = (em.size() == 0) && (ed.size() == 0);
        for (int i = 0; i < N; i++) begin
            if (mq[i].size() != 0 || dq[i].size() != 0) e = 0;
        end
        return e;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            s_meta_valid[i]           = mq[i].size() != 0;
            s_meta_data[i*MW +: MW]   = (mq[i].size() != 0) ? mq[i][0] : '0;
            s_data_valid[i]           = dq[i].size() != 0;
            s_data_data[i*DW +: DW]   = (dq[i].size() != 0) ? dq[i][0].d : '0;
            s_data_keep[i*KW +: KW]   = (dq[i].size() != 0) ? dq[i][0].k : '0;
            s_data_last[i]            = (dq[i].size() != 0) ? dq[i][0].l : 1'b0;
        end
    endtask

    // Requester driver plus stack-side monitor; sole writer of s_* inputs.
    task automatic run_driver();
        logic [N-1:0]  mhs;
        logic [N-1:0]  dhs;
        logic [MW-1:0] xm;
        beat_t         xd;
        s_meta_valid = '0; s_meta_data = '0;
        s_data_valid = '0; s_data_data = '0;
        s_data_keep  = '0; s_data_last = '0;
        forever begin
            @(negedge net_clk);
            mhs = s_meta_valid & s_meta_ready;
            dhs = s_data_valid & s_data_ready;
            if (m_meta_valid && m_meta_ready) begin
                tests++;
                if (em.size() == 0) begin
                    fails++;
                    $display("FAIL meta_order: got %h, required no meta", m_meta_data);
                end else begin
                    xm = em.pop_front();
                    if (m_meta_data !== xm) begin
                        fails++;
                        $display("FAIL meta_order: got %h, required %h", m_meta_data, xm);
                    end
                end
            end
            if (m_data_valid && m_data_ready) begin
                tests++;
                if (ed.size() == 0) begin
                    fails++;
                    $display("FAIL data_beat: got data %h, required no beat", m_data_data);
                end else begin
                    xd = ed.pop_front();
                    if ({m_data_data, m_data_keep, m_data_last} !== xd) begin
                        fails++;
                        $display("FAIL data_beat: got last=%0b keep=%h data=%h, required last=%0b keep=%h data=%h",
                                 m_data_last, m_data_keep, m_data_data, xd.l, xd.k, xd.d);
                    end
                end
            end
            @(posedge net_clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (mhs[i] && mq[i].size() != 0) void'(mq[i].pop_front());
                if (dhs[i] && dq[i].size() != 0) void'(dq[i].pop_front());
            end
            drive_inputs();
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge net_clk);
            if (all_empty()) break;
        end
        tests++;
        if (!all_empty()) begin
            fails++;
            $display("FAIL %s_drain: got %0d metas %0d beats pending, required 0",
                     name, em.size(), ed.size());
        end
        @(negedge net_clk);
    endtask

    task automatic test_reset();
        net_aresetn  = 1'b0;
        m_meta_ready = 1'b0;
        m_data_ready = 1'b0;
        clear_q();
        repeat (3) @(negedge net_clk);
        tests++;
        if ({m_meta_valid, s_meta_ready, s_data_ready, m_data_valid, grant_fifo_full} !== '0) begin
            fails++;
            $display("FAIL reset_state: got mv=%0b smr=%b sdr=%b dv=%0b full=%0b, required all 0",
                     m_meta_valid, s_meta_ready, s_data_ready, m_data_valid, grant_fifo_full);
        end
        @(posedge net_clk);
        #1 net_aresetn = 1'b1;
    endtask

    task automatic test_single_write();
        logic [MW-1:0] m;
        bit seen;
        test_reset();
        m_meta_ready = 1'b1;
        m_data_ready = 1'b1;
        m = mk_meta(1, 0, RC_RDMA_WRITE);
        mq[1].push_back(m); em.push_back(m);
        mk_pkt(1, 3);
        foreach (pk[j]) begin dq[1].push_back(pk[j]); ed.push_back(pk[j]); end
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge net_clk);
            if (s_meta_ready[1]) seen = 1;
        end
        tests++;
        if (!seen || m_meta_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_grant: got seen=%0b mv=%0b, required 1 0", seen, m_meta_valid);
        end
        @(negedge net_clk);
        tests++;
        if (m_meta_valid !== 1'b1) begin
            fails++;
            $display("FAIL single_latency: got mv=%0b, required 1", m_meta_valid);
        end
        wait_drain("single", 20);
        tests++;
        if (m_data_valid !== 1'b0 || s_data_ready !== '0 || grant_fifo_full !== 1'b0) begin
            fails++;
            $display("FAIL single_empty: got dv=%0b sdr=%b, required 0 0000",
                     m_data_valid, s_data_ready);
        end
    endtask

    task automatic test_rr_reads();
        logic [MW-1:0] m;
        int  gaps;
        bit  started;
        bit  sdr_seen;
        test_reset();
        m_meta_ready = 1'b1;
        m_data_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                m = mk_meta(i, r, RC_RDMA_READ);
                mq[i].push_back(m); em.push_back(m);
            end
        end
        gaps = 0; started = 0; sdr_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge net_clk);
            if (s_data_ready !== '0) sdr_seen = 1;
            if (m_meta_valid) started = 1;
            if (em.size() == 0) break;
            if (started && !m_meta_valid) gaps++;
        end
        tests++;
        if (gaps != 0) begin
            fails++;
            $display("FAIL rr_throughput: got %0d idle cycles, required 0", gaps);
        end
        tests++;
        if (sdr_seen) begin
            fails++;
            $display("FAIL rr_data_ready: got s_data_ready asserted, required never");
        end
        wait_drain("rr", 10);
    endtask

    task automatic test_order();
        logic [MW-1:0] m0, m2;
        beat_t p0 [$];
        beat_t p2 [$];
        test_reset();
        m_meta_ready = 1'b1;
        m_data_ready = 1'b1;
        mk_pkt(0, 4); p0 = pk;
        mk_pkt(2, 2); p2 = pk;
        foreach (p2[j]) dq[2].push_back(p2[j]);
        m0 = mk_meta(0, 0, RC_RDMA_WRITE);
        m2 = mk_meta(2, 0, RC_SEND);
        mq[0].push_back(m0); mq[2].push_back(m2);
        em.push_back(m0); em.push_back(m2);
        foreach (p0[j]) ed.push_back(p0[j]);
        foreach (p2[j]) ed.push_back(p2[j]);
        repeat (5) @(negedge net_clk);
        tests++;
        if (s_data_ready !== 4'b0001 || m_data_valid !== 1'b0) begin
            fails++;
            $display("FAIL order_wait: got sdr=%b dv=%0b, required 0001 0", s_data_ready, m_data_valid);
        end
        foreach (p0[j]) dq[0].push_back(p0[j]);
        wait_drain("order", 30);
    endtask

    task automatic test_fifo_full();
        logic [MW-1:0] m;
        bit seen;
        test_reset();
        m_meta_ready = 1'b1;
        m_data_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            m = mk_meta(k % N, k, RC_RDMA_WRITE);
            mq[k % N].push_back(m); em.push_back(m);
            mk_pkt(k % N, (k == 0) ? 1 : 1 + k % 3);
            foreach (pk[j]) begin hold[k % N].push_back(pk[j]); ed.push_back(pk[j]); end
        end
        repeat (14) @(negedge net_clk);
        tests++;
        if (grant_fifo_full !== 1'b1 || em.size() != 1 || s_meta_ready !== '0) begin
            fails++;
            $display("FAIL full_stall: got full=%0b pending=%0d smr=%b, required 1 1 0000",
                     grant_fifo_full, em.size(), s_meta_ready);
        end
        dq[0].push_back(hold[0].pop_front());
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge net_clk);
            if (m_data_valid && m_data_ready && m_data_last) seen = 1;
        end
        tests++;
        if (!seen || s_meta_ready !== 4'b0001) begin
            fails++;
            $display("FAIL full_pop_grant: got seen=%0b smr=%b, required 1 0001", seen, s_meta_ready);
        end
        @(negedge net_clk);
        tests++;
        if (grant_fifo_full !== 1'b1) begin
            fails++;
            $display("FAIL full_refill: got full=%0b, required 1", grant_fifo_full);
        end
        for (int i = 0; i < N; i++) begin
            while (hold[i].size() != 0) dq[i].push_back(hold[i].pop_front());
        end
        wait_drain("full", 60);
        tests++;
        if (grant_fifo_full !== 1'b0) begin
            fails++;
            $display("FAIL full_clear: got full=%0b, required 0", grant_fifo_full);
        end
    endtask

    task automatic test_backpressure();
        logic [MW-1:0] a, b;
        bit seen;
        test_reset();
        m_meta_ready = 1'b0;
        m_data_ready = 1'b1;
        a = mk_meta(1, 0, RC_RDMA_READ);
        b = mk_meta(1, 1, RC_RDMA_READ);
        mq[1].push_back(a); mq[1].push_back(b);
        em.push_back(a); em.push_back(b);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge net_clk);
            if (m_meta_valid) seen = 1;
        end
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (!seen || m_meta_data !== a || s_meta_ready !== '0) begin
                fails++;
                $display("FAIL bp_stable: cycle %0d got mv=%0b smr=%b data=%h, required 1 0000 %h",
                         c, m_meta_valid, s_meta_ready, m_meta_data, a);
            end
            @(negedge net_clk);
        end
        @(posedge net_clk);
        #1 m_meta_ready = 1'b1;
        wait_drain("bp", 10);
    endtask

    task automatic test_reset_mid_packet();
        logic [MW-1:0] m, m0, m3;
        bit seen;
        test_reset();
        m_meta_ready = 1'b1;
        m_data_ready = 1'b0;
        m = mk_meta(2, 0, RC_RDMA_WRITE);
        mq[2].push_back(m); em.push_back(m);
        mk_pkt(2, 4);
        foreach (pk[j]) begin dq[2].push_back(pk[j]); ed.push_back(pk[j]); end
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge net_clk);
            if (m_data_valid) seen = 1;
        end
        @(posedge net_clk);
        #1 m_data_ready = 1'b1;
        @(posedge net_clk);
        #1 m_data_ready = 1'b0;
        #2 net_aresetn = 1'b0;
        #1;
        tests++;
        if (!seen || {m_meta_valid, s_meta_ready, s_data_ready, m_data_valid, grant_fifo_full} !== '0) begin
            fails++;
            $display("FAIL async_reset: got seen=%0b mv=%0b smr=%b sdr=%b dv=%0b full=%0b, required 1 and all 0",
                     seen, m_meta_valid, s_meta_ready, s_data_ready, m_data_valid, grant_fifo_full);
        end
        clear_q();
        m0 = mk_meta(0, 1, RC_RDMA_READ);
        m3 = mk_meta(3, 1, RC_RDMA_READ);
        mq[0].push_back(m0); mq[3].push_back(m3);
        em.push_back(m0); em.push_back(m3);
        repeat (3) @(negedge net_clk);
        tests++;
        if (s_meta_valid !== 4'b1001 || s_meta_ready !== '0) begin
            fails++;
            $display("FAIL reset_hold: got smv=%b smr=%b, required 1001 0000", s_meta_valid, s_meta_ready);
        end
        @(posedge net_clk);
        #1 net_aresetn = 1'b1;
        m_data_ready = 1'b1;
        wait_drain("post_reset", 10);
    endtask

    initial begin
        net_aresetn  = 1'b0;
        m_meta_ready = 1'b0;
        m_data_ready = 1'b0;
        fork
            run_driver();
        join_none
        test_reset();
        test_single_write();
        test_rr_reads();
        test_order();
        test_fifo_full();
        test_backpressure();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
